debugger_decoder: RTL and testbench
===================================

Name: debugger_decoder

Overview:
- Byte-serial ASCII-hex to binary decoder for the MIPS debug link.
- Sits between the UART receiver and the debug command unit.
- Accepts one ASCII character per valid strobe and accumulates hex digits into a 1- to 4-byte word.
- Presents the completed word on result with a one-cycle done pulse; any non-hex character aborts the word and flags error.

Parameters:
- RESULT_W, 32: result width in bits; fixed at 32, must be a multiple of 8.
- NIBBLE_CNT_W, 4: width of the internal digit counter; must hold 0..8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; one clock, no other clock domains.
- code_valid  input  1  code holds a new character this cycle.
- code  input  8  ASCII character from the UART.
- size  input  2  word length: 0=1 byte, 1=2 bytes, 2=3 bytes, 3=4 bytes.
- result  output  32  last completed word, zero-extended.
- done  output  1  one-cycle pulse when result has just been updated.
- error  output  1  one-cycle pulse when a non-hex character was received.
- busy  output  1  high while a partial word is held (count != 0).

Behaviour:
- Reset (synchronous): result=0, done=0, error=0, digit count=0, shift register=0, latched size=0. Reset wins over a simultaneous code_valid.
- code_valid=0: hold all state; done and error are low.
- Hex digit classes:
  - '0'-'9' (0x30-0x39) map to 0-9.
  - 'A'-'F' (0x41-0x46) map to 10-15.
  - Lowercase is handled per Optional Feature.
  - All other values are non-hex, including '?'=0x3F.
- Valid hex digit:
  - shreg <= {shreg[27:0], nibble}; count increments.
  - On the first digit of a word (count==0), size is latched. Later changes to size are ignored until the word ends.
  - Target count N = 2*(latched_size+1), i.e. 2, 4, 6 or 8 digits. The first digit uses the current size input directly.
- Completion:
  - Triggered when the incoming digit makes count reach N.
  - Next edge: result <= the new shift-register value masked to N*4 bits, upper bits 0. done=1 for exactly that cycle. count=0, shreg=0.
  - Latency: done and result are valid the cycle after the final digit's valid edge.
- Non-hex character: error=1 for one cycle; count=0, shreg=0; result unchanged; done=0. This applies even when count==0.
- Back-to-back valid characters are accepted every cycle; there is no backpressure.
- The first digit of a new word may arrive in the same cycle done is high.
- result holds its value until the next completion or reset.
- done and error are never high in the same cycle.

Optional Feature:
- Macro DEBUGGER_DECODER_LOWERCASE_EN.
- Defined: 'a'-'f' (0x61-0x66) are accepted as 10-15, identical to uppercase.
- Undefined: 0x61-0x66 are non-hex and raise error.

Decomposition:
- Package debugger_decoder_pkg holds:
  - ASCII constants: ASCII_0=0x30, ASCII_9=0x39, ASCII_UA=0x41, ASCII_UF=0x46, ASCII_LA=0x61, ASCII_LF=0x66.
  - Size encodings: SIZE_1B..SIZE_4B.
  - RESULT_W.
- One combinational sub-module, ascii_hex_nibble:
  - Input: code[7:0]. Outputs: nibble[3:0], is_hex.
  - Contains the lowercase ifdef.
- The top holds the counter, the shift register and the output registers.

Test Plan:
- Reset: assert reset with code_valid=1 and code=0x38 -> result=0, done=0, error=0, busy=0 after release.
- size=0, send '3','F' -> done pulse one cycle after 'F'; result=0x0000003F.
- size=3, send "DEADBEEF" back-to-back -> busy high after 'D'; done after the 8th digit; result=0xDEADBEEF.
- size=1, send '1','2', then '?' (0x3F) -> error pulse, busy=0, result keeps its prior value. Then send '8','8','8','8' -> result=0x00008888.
- size=1 for the first digit, change size to 3 mid-word, send four digits "1234" -> completes at 4 digits; result=0x00001234.
- Lowercase 'a','b' with size=0:
  - With the macro defined -> result=0x000000AB.
  - Without it -> error on 'a'.

Source files
------------

// File: rtl/debugger_decoder_pkg.sv
// Shared constants and types for the ASCII-hex debug-link decoder.
package debugger_decoder_pkg;

  localparam int unsigned RESULT_W = 32;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_3B = 2'd2,
    SIZE_4B = 2'd3
  } size_e;

  // Keeps only the bytes belonging to a word of the given size.
  function automatic logic [RESULT_W-1:0] size_mask(size_e s);
    case (s)
      SIZE_1B: size_mask = 32'h0000_00FF;
      SIZE_2B: size_mask = 32'h0000_FFFF;
      SIZE_3B: size_mask = 32'h00FF_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/debugger_decoder_if.sv
// Character input and word output bundle between UART receiver and debug command unit.
interface debugger_decoder_if;
  import debugger_decoder_pkg::*;

  logic                code_valid;
  logic [7:0]          code;
  logic [1:0]          size;
  logic [RESULT_W-1:0] result;
  logic                done;
  logic                error;
  logic                busy;

  modport master (output code_valid, code, size,
                  input  result, done, error, busy);

  modport slave  (input  code_valid, code, size,
                  output result, done, error, busy);
endinterface

// File: rtl/debugger_decoder_ascii_hex_nibble.sv
// ASCII character to hex nibble classifier.
// DEBUGGER_DECODER_LOWERCASE_EN additionally accepts 'a'-'f'.
module ascii_hex_nibble
  import debugger_decoder_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (code >= ASCII_0 && code <= ASCII_9) begin
      nibble = code[3:0];
      is_hex = 1'b1;
    end else if (code >= ASCII_UA && code <= ASCII_UF) begin
      // 'A' has low nibble 1, so adding 9 lands on 10
      nibble = code[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`ifdef DEBUGGER_DECODER_LOWERCASE_EN
    else if (code >= ASCII_LA && code <= ASCII_LF) begin
      nibble = code[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/debugger_decoder.sv
// Byte-serial ASCII-hex to binary word decoder (1-4 byte words).
// Optional lowercase acceptance: define DEBUGGER_DECODER_LOWERCASE_EN.
module debugger_decoder #(
  parameter int unsigned RESULT_W     = debugger_decoder_pkg::RESULT_W,
  parameter int unsigned NIBBLE_CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  debugger_decoder_if.slave  bus
);
  import debugger_decoder_pkg::*;

  logic [NIBBLE_CNT_W-1:0] count, count_nxt, target;
  logic [RESULT_W-1:0]     shreg, shreg_nxt, result_q;
  logic                    done_q, error_q;
  size_e                   size_q, size_eff;
  logic [3:0]              nibble;
  logic                    is_hex;

  ascii_hex_nibble u_nibble (
    .code   (bus.code),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  // The first digit of a word sees the live size input; later digits use the latched copy.
  always_comb begin
    size_eff  = (count == '0) ? size_e'(bus.size) : size_q;
    target    = NIBBLE_CNT_W'({size_eff, 1'b0}) + NIBBLE_CNT_W'(2);
    count_nxt = count + NIBBLE_CNT_W'(1);
    shreg_nxt = {shreg[RESULT_W-5:0], nibble};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      shreg    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      size_q   <= SIZE_1B;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.code_valid) begin
        if (!is_hex) begin
          error_q <= 1'b1;
          count   <= '0;
          shreg   <= '0;
        end else if (count_nxt == target) begin
          result_q <= shreg_nxt & size_mask(size_eff);
          done_q   <= 1'b1;
          count    <= '0;
          shreg    <= '0;
        end else begin
          shreg <= shreg_nxt;
          count <= count_nxt;
          if (count == '0)
            size_q <= size_eff;
        end
      end
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.busy   = (count != '0);

endmodule

// File: tb/tb_debugger_decoder.sv
// Scoreboard bench for debugger_decoder: expected done/error events are queued at stimulus time.
module tb_debugger_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debugger_decoder_if bus ();

  debugger_decoder #(
    .RESULT_W     (32),
    .NIBBLE_CNT_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] result;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int unsigned m_count = 0;
  int unsigned m_size  = 0;
  logic [31:0] m_val   = '0;
  logic [31:0] m_result = '0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef DEBUGGER_DECODER_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
    return -1;
  endfunction

  task automatic send(input logic [7:0] c, input logic [1:0] sz);
    int v;
    ev_t e;
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code       = c;
    bus.size       = sz;
    v = hex_val(c);
    if (v < 0) begin
      e.is_err = 1'b1;
      e.result = m_result;
      exp_q.push_back(e);
      m_count = 0;
      m_val   = '0;
    end else begin
      if (m_count == 0) m_size = sz;
      m_val   = (m_val << 4) | 32'(v);
      m_count = m_count + 1;
      if (m_count == 2 * (m_size + 1)) begin
        m_result = m_val;
        e.is_err = 1'b0;
        e.result = m_result;
        exp_q.push_back(e);
        m_count = 0;
        m_val   = '0;
      end
    end
    @(posedge clk);
    #1;
    check_vec("busy", 32'(bus.busy), 32'(m_count != 0));
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    bus.code_valid = 1'b0;
    bus.code       = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_str(input string s, input logic [1:0] sz);
    for (int i = 0; i < s.len(); i++) send(s[i], sz);
  endtask

  // Output monitor: every done/error pulse must match the oldest queued event.
  always @(posedge clk) begin
    #1;
    if (reset !== 1'b1 && (bus.done === 1'b1 || bus.error === 1'b1)) begin
      check_vec("done_error_excl", 32'(bus.done & bus.error), 32'd0);
      if (exp_q.size() == 0) begin
        check_vec("unexpected_pulse", 32'(bus.error), 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_vec("pulse_kind_error", 32'(bus.error), 32'(e.is_err));
        check_vec("result", bus.result, e.result);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.code_valid = 1'b1;
    bus.code       = 8'h38;
    bus.size       = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset          = 1'b0;
    bus.code_valid = 1'b0;
    check_vec("rst_result", bus.result, 32'h0);
    check_vec("rst_done",   32'(bus.done),  32'h0);
    check_vec("rst_error",  32'(bus.error), 32'h0);
    check_vec("rst_busy",   32'(bus.busy),  32'h0);

    // One-byte word, then a 4-byte word whose first digit overlaps the done cycle
    send_str("3F", 2'd0);
    send_str("DEADBEEF", 2'd3);
    idle(2);
    check_vec("hold_result", bus.result, 32'hDEAD_BEEF);

    // Abort mid-word, result must survive
    send_str("12", 2'd1);
    send(8'h3F, 2'd1);
    check_vec("abort_result", bus.result, 32'hDEAD_BEEF);
    send_str("8888", 2'd1);

    // Non-hex with no partial word still flags error
    idle(1);
    send(8'h47, 2'd0);

    // Size changes after the first digit are ignored; idle gaps hold state
    send(8'h31, 2'd1);
    idle(3);
    check_vec("idle_busy", 32'(bus.busy), 32'h1);
    send(8'h32, 2'd3);
    send(8'h33, 2'd3);
    send(8'h34, 2'd3);
    check_vec("size_latch_result", bus.result, 32'h0000_1234);

    // Three-byte word and lowercase handling
    send_str("A5C3E1", 2'd2);
    send_str("ab", 2'd0);
    idle(4);
`ifdef DEBUGGER_DECODER_LOWERCASE_EN
    check_vec("lower_result", bus.result, 32'h0000_00AB);
`else
    check_vec("lower_result", bus.result, 32'h00A5_C3E1);
`endif

    check_vec("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
